// File: rtl/branch_resolve_unit.sv
// Registered branch-resolution stage: evaluates branches/jalr/traps, issues a held
// fetch redirect, a one-cycle predictor-training pulse and saturating mispredict counters.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_is_branch_i,
    input  logic                 in_is_jalr_i,
    input  logic                 in_is_trap_i,
    input  logic [5:0]           in_branch_op_i,
    input  logic [XLEN-1:0]      in_src1_i,
    input  logic [XLEN-1:0]      in_src2_i,
    input  logic [XLEN-1:0]      in_imm_i,
    input  logic [PC_WIDTH-1:0]  in_pc_i,
    input  logic [PC_WIDTH-1:0]  in_npc_i,
    input  logic [PC_WIDTH-1:0]  in_trap_target_i,
    input  logic                 in_pred_i,
    input  logic                 in_pred_local_i,
    input  logic                 in_pred_global_i,
    output logic                 redir_valid_o,
    input  logic                 redir_ready_i,
    output logic [PC_WIDTH-1:0]  redir_pc_o,
    output logic                 upd_valid_o,
    output logic [PC_WIDTH-1:0]  upd_pc_o,
    output logic                 upd_taken_o,
    output logic                 upd_ok_o,
    output logic                 upd_local_ok_o,
    output logic                 upd_global_ok_o,
    input  logic                 cnt_clear_i,
    output logic [CNT_WIDTH-1:0] cnt_branch_o,
    output logic [CNT_WIDTH-1:0] cnt_mispred_o,
    output logic [CNT_WIDTH-1:0] cnt_local_mispred_o,
    output logic [CNT_WIDTH-1:0] cnt_global_mispred_o
);

    typedef enum logic {IDLE, HOLD} state_t;
    state_t state;

    logic                eq, lt, ltu, taken, accept, br_acc, need_redir;
    logic                ok, local_ok, global_ok;
    logic [5:0]          cond;
    logic [PC_WIDTH-1:0] imm_pc, br_next, jalr_sum, actual_next;

    assign eq    = (in_src1_i == in_src2_i);
    assign lt    = ($signed(in_src1_i) < $signed(in_src2_i));
    assign ltu   = (in_src1_i < in_src2_i);
    assign cond  = {~ltu, ltu, ~lt, lt, ~eq, eq};
    assign taken = |(in_branch_op_i & cond);

    assign imm_pc   = in_imm_i[PC_WIDTH-1:0];
    assign br_next  = taken ? (in_pc_i + imm_pc) : (in_pc_i + PC_WIDTH'(4));
    assign jalr_sum = in_src1_i[PC_WIDTH-1:0] + imm_pc;

    always_comb begin
        actual_next = br_next;
        if (in_is_trap_i)      actual_next = in_trap_target_i;
        else if (in_is_jalr_i) actual_next = {jalr_sum[PC_WIDTH-1:1], 1'b0};
    end

    // Comparing against the followed PC catches both direction and target mispredicts.
    assign need_redir = in_is_trap_i | ((in_is_branch_i | in_is_jalr_i) & (actual_next != in_npc_i));
    assign in_ready_o = ~redir_valid_o;
    assign accept     = in_valid_i & in_ready_o;
    assign br_acc     = accept & in_is_branch_i;
    assign ok         = (taken == in_pred_i) & (actual_next == in_npc_i);
    assign local_ok   = (taken == in_pred_local_i);
    assign global_ok  = (taken == in_pred_global_i);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            redir_valid_o        <= 1'b0;
            redir_pc_o           <= '0;
            upd_valid_o          <= 1'b0;
            upd_pc_o             <= '0;
            upd_taken_o          <= 1'b0;
            upd_ok_o             <= 1'b0;
            upd_local_ok_o       <= 1'b0;
            upd_global_ok_o      <= 1'b0;
            cnt_branch_o         <= '0;
            cnt_mispred_o        <= '0;
            cnt_local_mispred_o  <= '0;
            cnt_global_mispred_o <= '0;
        end else begin
            upd_valid_o <= br_acc;
            if (br_acc) begin
                upd_pc_o        <= in_pc_i;
                upd_taken_o     <= taken;
                upd_ok_o        <= ok;
                upd_local_ok_o  <= local_ok;
                upd_global_ok_o <= global_ok;
            end
            case (state)
                IDLE: if (accept && need_redir) begin
                    state         <= HOLD;
                    redir_valid_o <= 1'b1;
                    redir_pc_o    <= actual_next;
                end
                HOLD: if (redir_ready_i) begin
                    state         <= IDLE;
                    redir_valid_o <= 1'b0;
                end
            endcase
            if (cnt_clear_i) begin
                cnt_branch_o         <= '0;
                cnt_mispred_o        <= '0;
                cnt_local_mispred_o  <= '0;
                cnt_global_mispred_o <= '0;
            end else begin
                cnt_branch_o         <= sat_inc(cnt_branch_o, br_acc);
                cnt_mispred_o        <= sat_inc(cnt_mispred_o, br_acc & ~ok);
                cnt_local_mispred_o  <= sat_inc(cnt_local_mispred_o, br_acc & ~local_ok);
                cnt_global_mispred_o <= sat_inc(cnt_global_mispred_o, br_acc & ~global_ok);
            end
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered, parametrised branch-resolution stage that replaces the purely combinational decode-stage branch unit. It accepts one control-flow instruction per cycle through a valid/ready handshake and evaluates conditional branches, jalr and trap returns (ecall/mret). It produces a held redirect request for fetch, a one-cycle predictor-training packet (combined, local and global correctness), and saturating misprediction counters. It sits between decode operand forwarding and the fetch PC mux and branch predictor.

## Interface
- XLEN, 32, operand/immediate width
- PC_WIDTH, 32, PC width (≤ XLEN)
- CNT_WIDTH, 32, performance counter width
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid_i  input  1  instruction offered
- in_ready_o  output  1  unit can accept
- in_is_branch_i / in_is_jalr_i / in_is_trap_i  input  1 each  instruction class (at most one set; none = non-control)
- in_branch_op_i  input  6  one-hot: [0]eq [1]ne [2]lt [3]ge [4]ltu [5]geu
- in_src1_i, in_src2_i  input  XLEN  forwarded rs1/rs2
- in_imm_i  input  XLEN  sign-extended immediate
- in_pc_i  input  PC_WIDTH  instruction PC
- in_npc_i  input  PC_WIDTH  PC fetch already followed
- in_trap_target_i  input  PC_WIDTH  mtvec/mepc target for traps
- in_pred_i, in_pred_local_i, in_pred_global_i  input  1 each  predicted taken (final, local, global)
- redir_valid_o  output  1  redirect pending
- redir_ready_i  input  1  fetch accepts redirect
- redir_pc_o  output  PC_WIDTH  redirect target
- upd_valid_o  output  1  training packet valid (one-cycle pulse)
- upd_pc_o  output  PC_WIDTH  PC of resolved branch
- upd_taken_o  output  1  actual direction
- upd_ok_o, upd_local_ok_o, upd_global_ok_o  output  1 each  prediction was correct
- cnt_clear_i  input  1  zero all counters
- cnt_branch_o, cnt_mispred_o, cnt_local_mispred_o, cnt_global_mispred_o  output  CNT_WIDTH each  counters

## Operation
- Accept = in_valid_i & in_ready_o; in_ready_o = ~redir_valid_o (combinational from state).
- Compare: eq/ne on XLEN equality; lt signed two's-complement, ltu unsigned; ge = ~lt, geu = ~ltu. taken = OR of (op bit & condition); only meaningful when in_is_branch_i.
- Targets (mod 2^PC_WIDTH, imm truncated to low PC_WIDTH bits): branch actual_next = taken ? pc+imm : pc+4; jalr actual_next = (src1+imm) with bit 0 cleared; trap actual_next = in_trap_target_i.
- Redirect needed: branch or jalr with actual_next != in_npc_i (covers direction and target mispredict); trap always; non-control never.
- State machine IDLE/HOLD. IDLE: accept with redirect-needed -> HOLD, latch redir_pc_o = actual_next. HOLD: redir_valid_o=1, redir_pc_o stable; redir_ready_i -> IDLE. in_valid_i ignored in HOLD.
- Training: on accepted branch only, next cycle upd_valid_o=1, upd_pc_o=in_pc_i, upd_taken_o=taken, upd_ok_o = (taken==in_pred_i) & (actual_next==in_npc_i), upd_local_ok_o = (taken==in_pred_local_i), upd_global_ok_o = (taken==in_pred_global_i). jalr/trap produce no packet.
- Counters, on accepted branch: cnt_branch +1; cnt_mispred +1 if ~upd_ok; local/global +1 if respective ok=0. Saturate at all-ones (no wrap). cnt_clear_i in same cycle as increment: clear wins, result 0.

## Timing
- Latency 1: accept in cycle N -> upd_valid_o, counters and redir_valid_o visible in N+1.
- Throughput: 1/cycle while no redirect; after a redirect-needed accept, next accept earliest the cycle after redir_ready_i sampled high.
- redir_valid_o, redir_pc_o held stable until handshake; redir_ready_i in same cycle redir_valid_o rises completes immediately (1-cycle HOLD).
- upd_valid_o is a single-cycle pulse, never asserted in two consecutive cycles for one instruction; payload don't-care when low.
- Reset (any cycle, incl. HOLD): state IDLE, redir_valid_o=0, redir_pc_o=0, upd_valid_o=0, upd_* payload 0, all counters 0; in_ready_o=1 the cycle after reset deasserts. Input accepted in the reset cycle is dropped.

## Test plan
- beq src1=src2=5, pc=0x100, imm=0x20, pred=1, npc=0x120 -> N+1 upd_valid=1, taken=1, ok=1, no redirect, cnt_branch=1, cnt_mispred=0.
- blt src1=0xFFFFFFFF, src2=1, pred=0, npc=0x104, pc=0x100, imm=0x40 -> taken=1, redir_valid=1 redir_pc=0x140, in_ready=0 until redir_ready, cnt_mispred=1; bltu same operands -> not taken.
- jalr src1=0x2001, imm=4, npc=0x2000 -> redir_pc=0x2004 (bit0 cleared), no upd_valid; same with npc=0x2004 -> no redirect.
- mret target 0x80, redir_ready held low 3 cycles -> redir_valid high 3 cycles with stable 0x80, inputs ignored, release on 4th.
- Counters with CNT_WIDTH=4: 17 mispredicted branches -> cnt_mispred=0xF saturated; cnt_clear_i with concurrent branch -> all 0.
- rst asserted while HOLD -> next cycle redir_valid=0, counters 0, in_ready=1 after reset release.
